// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the program sequencer and decode.
// Issues one instruction-memory request at a time, queues returned words with
// their PCs in a DEPTH-entry FIFO, and discards stale fetches on a flush.
// Optional feature macro: FETCH_BYPASS_EN (response bypass into an empty queue).
module fetch_unit #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DISCARD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;

    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic accept;
    logic resp_ok;
    logic push;
    logic pop;
    logic q_nonempty;

    assign q_nonempty = (count != '0);
    assign mem_addr   = addr_q;
    assign pc_ready   = accept;

    // Fetch acceptance and queue handshake decode
    always_comb begin
        // In IDLE nothing is in flight, so the space rule reduces to count < DEPTH.
        accept   = (state == IDLE) && pc_valid && !flush && !rst
                   && (count < CNT_W'(DEPTH));
        resp_ok  = (state == RESP) && mem_rvalid && !flush;
        pop      = q_nonempty && instr_ready;
`ifdef FETCH_BYPASS_EN
        // An empty queue lets the arriving word go straight to decode; if it is
        // taken this cycle it never occupies a queue slot.
        push     = resp_ok && !(!q_nonempty && instr_ready);
        if (!q_nonempty && resp_ok) begin
            instr_valid = 1'b1;
            instr       = mem_rdata;
            instr_pc    = addr_q;
        end else begin
            instr_valid = q_nonempty;
            instr       = q_data[rd_ptr];
            instr_pc    = q_pc[rd_ptr];
        end
`else
        push        = resp_ok;
        instr_valid = q_nonempty;
        instr       = q_data[rd_ptr];
        instr_pc    = q_pc[rd_ptr];
`endif
    end

    // Fetch FSM: one outstanding request, flush drops or discards it
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= pc_in;
                        mem_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= flush ? DISCARD : RESP;
                    end else if (flush) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: entry holds the fetched word and its PC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_data[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]   <= addr_q;
        end
    end

endmodule
